// File: rtl/seven_segment_scan_ctrl_if.sv
// Frame-load and display-drive bundle between a frame source and the scan controller.
// Purely combinational wiring, no latency.
// No backpressure: load is a strobe, load_ack and frame_start are single-cycle pulses.
interface seven_segment_scan_ctrl_if #(
   parameter int NUM_DIGITS = 4
);
   logic [4*NUM_DIGITS-1:0] digits_in;
   logic                    load;
   logic                    load_ack;
   logic                    frame_start;
   logic [3:0]              num;
   logic [NUM_DIGITS-1:0]   an;

   // Frame source / test side.
   modport master (
      output digits_in, load,
      input  load_ack, frame_start, num, an
   );

   // Scan controller side.
   modport slave (
      input  digits_in, load,
      output load_ack, frame_start, num, an
   );
endinterface

// File: rtl/seven_segment_scan_ctrl.sv
// Time-multiplexed common-anode seven-segment scan controller with tear-free frame commit.
// Outputs registered; a load shows up at the next frame start after the load is seen.
// No backpressure: loads overwrite the pending frame, one ack per committed frame.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zero digits, digit 0 always lit).
module seven_segment_scan_ctrl #(
   parameter int NUM_DIGITS = 4,
   parameter int CLK_DIV    = 50000,
   parameter int BLANK_CYC  = 8
) (
   input logic                    clk,
   input logic                    rst,
   seven_segment_scan_ctrl_if.slave bus
);
   localparam int CNT_MAX = (CLK_DIV > BLANK_CYC) ? CLK_DIV : BLANK_CYC;
   localparam int CW      = $clog2(CNT_MAX);
   localparam int IW      = $clog2(NUM_DIGITS);
   localparam int FW      = 4 * NUM_DIGITS;

   typedef enum logic {BLANK = 1'b0, DRIVE = 1'b1} state_t;

   state_t                state, state_n;
   logic [CW-1:0]         cnt, cnt_n;
   logic [IW-1:0]         idx, idx_n;
   logic [FW-1:0]         active, active_n;
   logic [FW-1:0]         pending, pending_n;
   logic                  pend_vld, pend_vld_n;
   logic [NUM_DIGITS-1:0] an, an_n;
   logic [3:0]            num, num_n;
   logic                  load_ack, load_ack_n;
   logic                  frame_start, frame_start_n;
   logic [NUM_DIGITS-1:0] sel_oh;

`ifdef LEADING_ZERO_BLANK_EN
   // True when digit sel is above digit 0 and it plus every more-significant nibble is zero.
   function automatic logic lead_zero(input logic [FW-1:0] f, input logic [IW-1:0] sel);
      logic z;
      z = (sel != '0);
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (i >= int'(sel) && f[4*i +: 4] != 4'd0) z = 1'b0;
      end
      return z;
   endfunction
`endif

   // State and all output registers; reset discards any pending frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= BLANK;
         cnt         <= '0;
         idx         <= IW'(NUM_DIGITS - 1);
         active      <= '0;
         pending     <= '0;
         pend_vld    <= 1'b0;
         an          <= '1;
         num         <= 4'd0;
         load_ack    <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         idx         <= idx_n;
         active      <= active_n;
         pending     <= pending_n;
         pend_vld    <= pend_vld_n;
         an          <= an_n;
         num         <= num_n;
         load_ack    <= load_ack_n;
         frame_start <= frame_start_n;
      end
   end

   // Next-state: blank gap, then drive one digit; commit pending frame when the scan wraps to digit 0.
   always_comb begin
      state_n       = state;
      cnt_n         = cnt + CW'(1);
      idx_n         = idx;
      active_n      = active;
      pending_n     = pending;
      pend_vld_n    = pend_vld;
      an_n          = an;
      num_n         = num;
      load_ack_n    = 1'b0;
      frame_start_n = 1'b0;
      sel_oh        = '0;

      case (state)
         BLANK: begin
            an_n = '1;
            if (cnt == CW'(BLANK_CYC - 1)) begin
               cnt_n   = '0;
               state_n = DRIVE;
               idx_n   = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
               if (idx_n == '0) begin
                  frame_start_n = 1'b1;
                  if (pend_vld) begin
                     active_n   = pending;
                     load_ack_n = 1'b1;
                     pend_vld_n = 1'b0;
                  end
               end
               // Decoder sees the newly committed frame on the same edge the digit lights.
               num_n  = active_n[4*idx_n +: 4];
               sel_oh = NUM_DIGITS'(1) << idx_n;
`ifdef LEADING_ZERO_BLANK_EN
               an_n   = lead_zero(active_n, idx_n) ? '1 : ~sel_oh;
`else
               an_n   = ~sel_oh;
`endif
            end
         end
         DRIVE: begin
            if (cnt == CW'(CLK_DIV - 1)) begin
               cnt_n   = '0;
               state_n = BLANK;
               an_n    = '1;
            end
         end
         default: begin
            state_n = BLANK;
            cnt_n   = '0;
            an_n    = '1;
         end
      endcase

      // A load on the commit edge targets the following frame, so it is applied last.
      if (bus.load) begin
         pending_n  = bus.digits_in;
         pend_vld_n = 1'b1;
      end
   end

   assign bus.an          = an;
   assign bus.num         = num;
   assign bus.load_ack    = load_ack;
   assign bus.frame_start = frame_start;
endmodule

// File: tb/tb_seven_segment_scan_ctrl.sv
// Directed bench for the scan controller (4 digits, 4-cycle drive, 1-cycle blank).
// Outputs sampled 1 time unit after the rising edge, inputs driven at the same point.
// Table rows hold a cycle count, a load strobe for the first cycle, and the expected outputs.
module tb_seven_segment_scan_ctrl;
   localparam int ND = 4;

`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [3:0] D1Z = 4'b1111, D2Z = 4'b1111, D3Z = 4'b1111;
`else
   localparam logic [3:0] D1Z = 4'b1101, D2Z = 4'b1011, D3Z = 4'b0111;
`endif

   typedef struct {
      int          n;
      logic        ld;
      logic [15:0] din;
      logic [3:0]  an;
      logic [3:0]  num;
      logic        ack;
      logic        fs;
   } vec_t;

   logic clk;
   logic rst;
   int   compared;
   int   mismatched;
   vec_t tbl[$];

   seven_segment_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

   seven_segment_scan_ctrl #(
      .NUM_DIGITS(ND),
      .CLK_DIV   (4),
      .BLANK_CYC (1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic add(input int n, input logic ld, input logic [15:0] din,
                      input logic [3:0] an, input logic [3:0] num,
                      input logic ack, input logic fs);
      tbl.push_back('{n, ld, din, an, num, ack, fs});
   endtask

   task automatic run_range(input int lo, input int hi);
      for (int r = lo; r < hi; r++) begin
         bus.load      = tbl[r].ld;
         bus.digits_in = tbl[r].din;
         for (int k = 0; k < tbl[r].n; k++) begin
            tick();
            bus.load = 1'b0;
            chk($sformatf("row%0d.%0d an", r, k), 32'(bus.an), 32'(tbl[r].an));
            chk($sformatf("row%0d.%0d num", r, k), 32'(bus.num), 32'(tbl[r].num));
            chk($sformatf("row%0d.%0d ack", r, k), 32'(bus.load_ack), (k == 0) ? 32'(tbl[r].ack) : 32'd0);
            chk($sformatf("row%0d.%0d fs", r, k), 32'(bus.frame_start), (k == 0) ? 32'(tbl[r].fs) : 32'd0);
         end
      end
   endtask

   // One 4-cycle digit slot followed by its 1-cycle blank gap.
   task automatic slot(input logic [3:0] an, input logic [3:0] num);
      add(4, 1'b0, 16'h0, an, num, 1'b0, 1'b0);
      add(1, 1'b0, 16'h0, 4'b1111, num, 1'b0, 1'b0);
   endtask

   int seg_a;
   int acks;
   int starts;
   int num_nz;

   initial begin
      compared   = 0;
      mismatched = 0;

      // Segment A: first frame shows zeros, 1234 loaded on the first commit edge, then AAAA/5678 overwrite.
      add(1, 1'b1, 16'h1234, 4'b1110, 4'h0, 1'b0, 1'b1);
      add(3, 1'b0, 16'h0, 4'b1110, 4'h0, 1'b0, 1'b0);
      add(1, 1'b0, 16'h0, 4'b1111, 4'h0, 1'b0, 1'b0);
      slot(D1Z, 4'h0); slot(D2Z, 4'h0); slot(D3Z, 4'h0);
      add(1, 1'b0, 16'h0, 4'b1110, 4'h4, 1'b1, 1'b1);
      add(3, 1'b0, 16'h0, 4'b1110, 4'h4, 1'b0, 1'b0);
      add(1, 1'b0, 16'h0, 4'b1111, 4'h4, 1'b0, 1'b0);
      slot(4'b1101, 4'h3); slot(4'b1011, 4'h2); slot(4'b0111, 4'h1);
      add(1, 1'b0, 16'h0, 4'b1110, 4'h4, 1'b0, 1'b1);
      add(1, 1'b1, 16'hAAAA, 4'b1110, 4'h4, 1'b0, 1'b0);
      add(1, 1'b1, 16'h5678, 4'b1110, 4'h4, 1'b0, 1'b0);
      add(1, 1'b0, 16'h0, 4'b1110, 4'h4, 1'b0, 1'b0);
      add(1, 1'b0, 16'h0, 4'b1111, 4'h4, 1'b0, 1'b0);
      slot(4'b1101, 4'h3); slot(4'b1011, 4'h2); slot(4'b0111, 4'h1);
      add(1, 1'b0, 16'h0, 4'b1110, 4'h8, 1'b1, 1'b1);
      add(3, 1'b0, 16'h0, 4'b1110, 4'h8, 1'b0, 1'b0);
      add(1, 1'b0, 16'h0, 4'b1111, 4'h8, 1'b0, 1'b0);
      slot(4'b1101, 4'h7); slot(4'b1011, 4'h6); slot(4'b0111, 4'h5);
      add(1, 1'b0, 16'h0, 4'b1110, 4'h8, 1'b0, 1'b1);
      seg_a = tbl.size();

      // Segment B (after a fresh reset): 0042 loaded at first edge, 0000 loaded on its commit edge.
      add(1, 1'b1, 16'h0042, 4'b1110, 4'h0, 1'b0, 1'b1);
      add(3, 1'b0, 16'h0, 4'b1110, 4'h0, 1'b0, 1'b0);
      add(1, 1'b0, 16'h0, 4'b1111, 4'h0, 1'b0, 1'b0);
      slot(D1Z, 4'h0); slot(D2Z, 4'h0); slot(D3Z, 4'h0);
      add(1, 1'b1, 16'h0000, 4'b1110, 4'h2, 1'b1, 1'b1);
      add(3, 1'b0, 16'h0, 4'b1110, 4'h2, 1'b0, 1'b0);
      add(1, 1'b0, 16'h0, 4'b1111, 4'h2, 1'b0, 1'b0);
      slot(4'b1101, 4'h4); slot(D2Z, 4'h0); slot(D3Z, 4'h0);
      add(1, 1'b0, 16'h0, 4'b1110, 4'h0, 1'b1, 1'b1);
      add(3, 1'b0, 16'h0, 4'b1110, 4'h0, 1'b0, 1'b0);
      add(1, 1'b0, 16'h0, 4'b1111, 4'h0, 1'b0, 1'b0);
      slot(D1Z, 4'h0);

      // Reset state.
      rst           = 1'b1;
      bus.load      = 1'b0;
      bus.digits_in = 16'h0;
      tick();
      tick();
      chk("reset an", 32'(bus.an), 32'hF);
      chk("reset num", 32'(bus.num), 32'h0);
      chk("reset ack", 32'(bus.load_ack), 32'h0);
      chk("reset fs", 32'(bus.frame_start), 32'h0);
      rst = 1'b0;

      run_range(0, seg_a);

      // Mid-DRIVE async reset with a pending load that must never be acknowledged.
      bus.load      = 1'b1;
      bus.digits_in = 16'h9999;
      tick();
      bus.load = 1'b0;
      chk("pre-rst num", 32'(bus.num), 32'h8);
      #3;
      rst = 1'b1;
      #1;
      chk("async rst an", 32'(bus.an), 32'hF);
      chk("async rst num", 32'(bus.num), 32'h0);
      tick();
      tick();
      rst    = 1'b0;
      acks   = 0;
      starts = 0;
      num_nz = 0;
      for (int c = 0; c < 45; c++) begin
         tick();
         if (c == 0) chk("post-rst first an", 32'(bus.an), 32'hE);
         if (bus.load_ack) acks++;
         if (bus.frame_start) starts++;
         if (bus.num != 4'd0) num_nz++;
      end
      chk("post-rst acks", 32'(acks), 32'd0);
      chk("post-rst frame starts", 32'(starts), 32'd3);
      chk("post-rst nonzero num", 32'(num_nz), 32'd0);

      rst = 1'b1;
      tick();
      rst = 1'b0;
      run_range(seg_a, tbl.size());

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
